// File: rtl/radix_2_div.sv
// ============================================================================
// radix_2_div : iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional DIV_FAST_SPECIAL_EN: divide-by-zero and overflow skip the iterations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module radix_2_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        div_in_valid,
  input  logic [1:0]  div_type,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        cpu_busy,
  output logic [31:0] div_out,
  output logic        div_out_valid,
  output logic        div_busy
);

  localparam logic [1:0] DIV_WAIT_VALID  = 2'd0;
  localparam logic [1:0] DIV_PRE_COMPUTE = 2'd1;
  localparam logic [1:0] DIV_COMPUTE     = 2'd2;
  localparam logic [1:0] DIV_DONE        = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  type_q, type_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] dvs_mag_q, dvs_mag_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        quo_neg_q, quo_neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic        div0_q, div0_d;
  logic        ovf_q, ovf_d;
  logic [31:0] div_out_q, div_out_d;

  logic        w_signed;
  logic [31:0] w_dvd_mag;
  logic [31:0] w_dvs_mag;
  logic        w_div0;
  logic        w_ovf;
  logic [32:0] w_shifted;
  logic [32:0] w_trial;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic [31:0] w_quo_fin;
  logic [31:0] w_rem_fin;

  // Override result for divide-by-zero / signed overflow.
  function automatic logic [31:0] special_result(input logic div0, input logic rem_sel,
                                                 input logic [31:0] dvd);
    if (div0)
      return rem_sel ? dvd : 32'hFFFF_FFFF;
    else
      return rem_sel ? 32'h0000_0000 : 32'h8000_0000;
  endfunction

  always_comb begin
    w_signed  = ~type_q[0];
    // Two's-complement negate; 0x80000000 maps to itself, which read unsigned is 2^31.
    w_dvd_mag = (w_signed && dvd_q[31]) ? (~dvd_q + 32'd1) : dvd_q;
    w_dvs_mag = (w_signed && dvs_q[31]) ? (~dvs_q + 32'd1) : dvs_q;
    w_div0    = (dvs_q == 32'd0);
    w_ovf     = w_signed && (dvd_q == 32'h8000_0000) && (dvs_q == 32'hFFFF_FFFF);

    w_shifted = {rem_q, quo_q[31]};
    w_trial   = w_shifted - {1'b0, dvs_mag_q};
    if (!w_trial[32]) begin
      w_rem_nx = w_trial[31:0];
      w_quo_nx = {quo_q[30:0], 1'b1};
    end else begin
      w_rem_nx = w_shifted[31:0];
      w_quo_nx = {quo_q[30:0], 1'b0};
    end
    w_quo_fin = quo_neg_q ? (~w_quo_nx + 32'd1) : w_quo_nx;
    w_rem_fin = rem_neg_q ? (~w_rem_nx + 32'd1) : w_rem_nx;
  end

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    dvs_mag_d = dvs_mag_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    div_out_d = div_out_q;

    case (state_q)
      DIV_WAIT_VALID: begin
        if (div_in_valid) begin
          state_d = DIV_PRE_COMPUTE;
          type_d  = div_type;
          dvd_d   = dividend;
          dvs_d   = divisor;
        end
      end
      DIV_PRE_COMPUTE: begin
        dvs_mag_d = w_dvs_mag;
        quo_d     = w_dvd_mag;
        rem_d     = 32'd0;
        cnt_d     = 6'd0;
        quo_neg_d = w_signed && (dvd_q[31] ^ dvs_q[31]) && !w_div0;
        rem_neg_d = w_signed && dvd_q[31];
        div0_d    = w_div0;
        ovf_d     = w_ovf;
        state_d   = DIV_COMPUTE;
`ifdef DIV_FAST_SPECIAL_EN
        if (w_div0 || w_ovf) begin
          state_d   = DIV_DONE;
          div_out_d = special_result(w_div0, type_q[1], dvd_q);
        end
`endif
      end
      DIV_COMPUTE: begin
        rem_d = w_rem_nx;
        quo_d = w_quo_nx;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = DIV_DONE;
          if (div0_q || ovf_q)
            div_out_d = special_result(div0_q, type_q[1], dvd_q);
          else
            div_out_d = type_q[1] ? w_rem_fin : w_quo_fin;
        end
      end
      DIV_DONE: begin
        if (!cpu_busy)
          state_d = DIV_WAIT_VALID;
      end
      default: state_d = DIV_WAIT_VALID;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DIV_WAIT_VALID;
      type_q    <= 2'd0;
      dvd_q     <= 32'd0;
      dvs_q     <= 32'd0;
      dvs_mag_q <= 32'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      cnt_q     <= 6'd0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      div_out_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      dvs_mag_q <= dvs_mag_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      div_out_q <= div_out_d;
    end
  end

  assign div_out       = div_out_q;
  assign div_out_valid = (state_q == DIV_DONE);
  assign div_busy      = (state_q != DIV_WAIT_VALID);

endmodule

`default_nettype wire

// File: tb/tb_radix_2_div.sv
// ============================================================================
// tb_radix_2_div : directed + scoreboard bench for radix_2_div.
// Honours DIV_FAST_SPECIAL_EN for special-case latency.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_radix_2_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_in_valid = 1'b0;
  logic [1:0]  div_type = 2'd0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        cpu_busy = 1'b0;
  logic [31:0] div_out;
  logic        div_out_valid;
  logic        div_busy;

  radix_2_div dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .div_in_valid (div_in_valid),
    .div_type     (div_type),
    .dividend     (dividend),
    .divisor      (divisor),
    .cpu_busy     (cpu_busy),
    .div_out      (div_out),
    .div_out_valid(div_out_valid),
    .div_busy     (div_busy)
  );

  always #5 clk = ~clk;

`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPEC_LAT = 2;
`else
  localparam int SPEC_LAT = 34;
`endif
  localparam int NORM_LAT = 34;

  localparam logic [1:0] T_DIV  = 2'b00;
  localparam logic [1:0] T_DIVU = 2'b01;
  localparam logic [1:0] T_REM  = 2'b10;
  localparam logic [1:0] T_REMU = 2'b11;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model(input logic [1:0] t, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb2;
    sa  = a;
    sb2 = b;
    if (b == 32'd0) return t[1] ? a : 32'hFFFF_FFFF;
    if (!t[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return t[1] ? 32'd0 : 32'h8000_0000;
    if (!t[0]) return t[1] ? sa % sb2 : sa / sb2;
    return t[1] ? a % b : a / b;
  endfunction

  function automatic int model_lat(input logic [1:0] t, input logic [31:0] a,
                                   input logic [31:0] b);
    if (b == 32'd0) return SPEC_LAT;
    if (!t[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return SPEC_LAT;
    return NORM_LAT;
  endfunction

  // Issue one request, scramble operands afterwards, collect and compare the result.
  task automatic do_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat,
                       input int hold, input bit pulse);
    exp_t e;
    int   lat;
    int   busy_n;
    div_type     = t;
    dividend     = a;
    divisor      = b;
    div_in_valid = 1'b1;
    cpu_busy     = (hold > 0);
    e.res = exp_res;
    e.lat = exp_lat;
    sb.push_back(e);
    @(posedge clk); #1;
    div_in_valid = 1'b0;
    dividend     = $urandom;
    divisor      = $urandom;
    div_type     = 2'($urandom_range(3));
    lat    = 1;
    busy_n = div_busy ? 1 : 0;
    while (!div_out_valid && lat < 200) begin
      div_in_valid = (pulse && lat == 10);
      @(posedge clk); #1;
      lat++;
      if (div_busy) busy_n++;
    end
    div_in_valid = 1'b0;
    e = sb.pop_front();
    check("result", div_out, e.res);
    check("latency", lat, e.lat);
    check("busy_cycles", busy_n, e.lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, div_out_valid}, 32'd1);
      check("hold_result", div_out, e.res);
    end
    cpu_busy = 1'b0;
    @(posedge clk); #1;
    check("after_valid", {31'd0, div_out_valid}, 32'd0);
    check("after_busy", {31'd0, div_busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rt;
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out", div_out, 32'd0);
    check("reset_valid", {31'd0, div_out_valid}, 32'd0);
    check("reset_busy", {31'd0, div_busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(T_DIVU, 32'd100, 32'd7, 32'h0000_000E, NORM_LAT, 0, 1'b0);
    do_op(T_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NORM_LAT, 0, 1'b0);
    do_op(T_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NORM_LAT, 0, 1'b0);
    do_op(T_REMU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, NORM_LAT, 0, 1'b0);
    do_op(T_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, NORM_LAT, 0, 1'b0);
    do_op(T_REM,  32'd7, 32'hFFFF_FFFE, 32'h0000_0001, NORM_LAT, 0, 1'b0);

    do_op(T_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, SPEC_LAT, 0, 1'b0);
    do_op(T_REMU, 32'd5, 32'd0, 32'h0000_0005, SPEC_LAT, 0, 1'b0);
    do_op(T_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPEC_LAT, 0, 1'b0);
    do_op(T_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT, 0, 1'b0);
    do_op(T_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPEC_LAT, 0, 1'b0);
    do_op(T_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, NORM_LAT, 0, 1'b0);

    do_op(T_DIV, 32'd20, 32'd3, 32'h0000_0006, NORM_LAT, 5, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_pulse", {31'd0, div_busy}, 32'd0);

    for (int k = 0; k < 4; k++) begin
      rt = 2'($urandom_range(3));
      ra = $urandom;
      rb = (k == 3) ? 32'($urandom_range(1, 255)) : $urandom;
      do_op(rt, ra, rb, model(rt, ra, rb), model_lat(rt, ra, rb), 0, 1'b0);
    end

    div_type     = T_DIVU;
    dividend     = 32'd1000;
    divisor      = 32'd9;
    div_in_valid = 1'b1;
    @(posedge clk); #1;
    div_in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out", div_out, 32'd0);
    check("abort_busy", {31'd0, div_busy}, 32'd0);
    check("abort_valid", {31'd0, div_out_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(T_DIVU, 32'd9, 32'd3, 32'h0000_0003, NORM_LAT, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
